tdc_read_ctrl: RTL
==================

Name: tdc_read_ctrl

Overview:
Sequences result readout from the external TDC chip after each measurement. A single-cycle read request (from the stop-edge pulse generator) arms the block. It waits for the chip's active-low interrupt, then reads NUM_RESULTS result registers over the parallel bus. Each word is presented on a valid/ready stream to the downstream buffer, and the chip is re-initialised for the next measurement.

Parameters:
NUM_RESULTS, 2, number of consecutive result registers read per measurement (1..8)
BASE_ADDR, 0, TDC address of the first result register; register i is at BASE_ADDR+i
ADDR_W, 4, TDC address bus width
DATA_W, 16, TDC data bus width
RD_CYCLES, 3, clk cycles tdc_rd_n is held low per access (>=1)
TIMEOUT, 1023, max clk cycles waited for interrupt before abort (>=1)

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
read  in  1  single-cycle read request, one per TDC stop edge
tdc_int_n  in  1  TDC interrupt, active-low, asynchronous; 2-flop synchronised internally
tdc_data  in  DATA_W  TDC read data bus
tdc_addr  out  ADDR_W  TDC register address
tdc_rd_n  out  1  TDC read strobe, active-low
tdc_init  out  1  one-cycle pulse re-arming the TDC
out_data  out  DATA_W  captured result word
out_idx  out  3  result index 0..NUM_RESULTS-1 of out_data
out_valid  out  1  out_data/out_idx valid
out_ready  in  1  downstream accepts word when out_valid&out_ready
busy  out  1  high in every state except IDLE
timeout_err  out  1  one-cycle pulse on interrupt timeout
overrun  out  1  one-cycle pulse when read arrives while busy

Behaviour:
- Reset (synchronous, checked at clk edge, overrides everything including mid-read):
  - state=IDLE; tdc_addr=0; tdc_rd_n=1; tdc_init=0; out_valid=0; out_data=0; out_idx=0; busy=0; timeout_err=0; overrun=0.
  - Index, strobe and timeout counters cleared; synchroniser flops set to 1 (interrupt inactive).
- States: IDLE, WAIT_INT, SETUP, STROBE, PUSH, INIT.
- IDLE: read=1 -> WAIT_INT, timeout counter=0, idx=0.
- WAIT_INT:
  - int_sync=0 -> SETUP.
  - Otherwise counter increments. Counter reaching TIMEOUT without int_sync=0 -> pulse timeout_err, go to INIT. Nothing is pushed.
- SETUP (1 cycle): tdc_addr=BASE_ADDR+idx, truncated to ADDR_W; tdc_rd_n=1 -> STROBE.
- STROBE: tdc_rd_n=0 for exactly RD_CYCLES cycles, tdc_addr held.
  - On the last low cycle, tdc_data is registered into out_data and out_idx=idx.
  - Next cycle: tdc_rd_n=1, state=PUSH, out_valid=1.
- PUSH: out_valid, out_data and out_idx hold stable until out_valid&out_ready. On that cycle out_valid drops next cycle, and:
  - idx<NUM_RESULTS-1: idx++ -> SETUP.
  - else -> INIT.
- INIT (1 cycle): tdc_init=1 -> IDLE. tdc_addr returns to 0.
- Access latency, ready held high: read-to-first-out_valid = 2 (sync) + 1 (WAIT_INT) + 1 (SETUP) + RD_CYCLES cycles after int_n falls.
- Back-to-back words with ready high: 1 PUSH + 1 SETUP + RD_CYCLES cycles each.
- read while busy=1 (any non-IDLE state): ignored, overrun pulses 1 cycle, sequence unaffected.
- read on the same cycle INIT exits to IDLE: ignored with overrun. Only read sampled in IDLE starts a sequence.
- int_n already low when read arrives: proceeds to SETUP on the next cycle (level sensitive).
- int_n deasserting during SETUP/STROBE/PUSH: no effect.
- out_ready stalls indefinitely: block waits in PUSH, no timeout, no further TDC accesses.
- tdc_rd_n never low in any state other than STROBE; tdc_init never coincides with tdc_rd_n=0.

Test Plan:
- Nominal, NUM_RESULTS=2, RD_CYCLES=3, ready=1: pulse read; drop int_n after 10 cycles; tdc_data=16'hA5A5 for addr 0, 16'h1234 for addr 1.
  -> two words (A5A5, idx 0) then (1234, idx 1); tdc_rd_n low exactly 3 cycles per access; one tdc_init pulse; busy drops after INIT.
- Backpressure: same stimulus with out_ready=0 for 20 cycles on the first word.
  -> out_valid/out_data=A5A5 held 20 cycles; no second tdc_rd_n low until accept; second word follows normally.
- Timeout, TIMEOUT=15: pulse read, keep int_n=1.
  -> timeout_err pulses at cycle 15 of WAIT_INT; tdc_init pulses next; no out_valid, tdc_rd_n never low; IDLE after.
- Overrun: pulse read again during STROBE of the first access.
  -> overrun=1 for one cycle; exactly 2 words still delivered; only one tdc_init.
- Reset mid-operation: assert reset during second STROBE.
  -> next edge: tdc_rd_n=1, out_valid=0, busy=0, state IDLE. A fresh read afterwards completes a full nominal sequence.
- Pre-asserted interrupt: int_n=0 before read.
  -> first tdc_rd_n falls 2 cycles after read sampled in IDLE (WAIT_INT 1 cycle, SETUP 1 cycle).

Source files
------------

// File: rtl/tdc_read_ctrl.sv
// tdc_read_ctrl
// Reads the results out of the external TDC chip after each measurement.
// A read request arms the block. The block then waits for the chip's
// active-low interrupt. It reads NUM_RESULTS consecutive result registers over
// the parallel bus and hands each word to a valid/ready stream. Finally it
// pulses tdc_init so the chip re-arms for the next stop edge.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   read              one-cycle request from the stop-edge pulse generator
//   tdc_int_n         asynchronous chip interrupt (active-low), synchronised here
//   tdc_data          chip read data bus
//   tdc_addr          chip register address (0 when not accessing)
//   tdc_rd_n          chip read strobe (active-low)
//   tdc_init          one-cycle chip re-init pulse
//   out_data/out_idx  captured word and its result index
//   out_valid/ready   downstream handshake
//   busy              high whenever a sequence is in progress
//   timeout_err       one-cycle pulse when the interrupt never arrived
//   overrun           one-cycle pulse when a read arrives while busy
module tdc_read_ctrl #(
    parameter int NUM_RESULTS = 2,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 16,
    parameter int RD_CYCLES   = 3,
    parameter int TIMEOUT     = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              tdc_int_n,
    input  logic [DATA_W-1:0] tdc_data,
    output logic [ADDR_W-1:0] tdc_addr,
    output logic              tdc_rd_n,
    output logic              tdc_init,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              timeout_err,
    output logic              overrun
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INT,
        SETUP,
        STROBE,
        PUSH,
        INIT
    } state_t;

    // The timeout counter must be able to hold TIMEOUT itself, because it
    // increments once more on the expiry cycle.
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SCNT_W = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;

    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(RD_CYCLES - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(NUM_RESULTS - 1);

    state_t state;
    state_t next_state;

    logic              int_meta;
    logic              int_sync;
    logic [TCNT_W-1:0] tcnt;
    logic [SCNT_W-1:0] scnt;
    logic [2:0]        idx;

    logic              wait_expired;
    logic              strobe_last;
    logic [ADDR_W-1:0] cur_addr;

    assign wait_expired = (tcnt == TCNT_LAST);
    assign strobe_last  = (scnt == SCNT_LAST);
    assign cur_addr     = ADDR_W'(BASE_ADDR + int'(idx));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Only a read seen in IDLE starts a sequence. A read
    // that arrives in the INIT cycle is therefore dropped even though the
    // block returns to IDLE on the same edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (read) next_state = WAIT_INT;
            WAIT_INT: begin
                if (!int_sync) begin
                    next_state = SETUP;
                end else if (wait_expired) begin
                    next_state = INIT;
                end
            end
            SETUP:    next_state = STROBE;
            STROBE:   if (strobe_last) next_state = PUSH;
            PUSH: begin
                if (out_ready) begin
                    next_state = (idx < IDX_LAST) ? SETUP : INIT;
                end
            end
            INIT:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Datapath registers: interrupt synchroniser, counters and the captured
    // word. The synchroniser resets to 1 so that the interrupt reads as
    // inactive until the chip really drives it low.
    always_ff @(posedge clk) begin
        if (reset) begin
            int_meta <= 1'b1;
            int_sync <= 1'b1;
            tcnt     <= '0;
            scnt     <= '0;
            idx      <= '0;
            out_data <= '0;
            out_idx  <= '0;
        end else begin
            int_meta <= tdc_int_n;
            int_sync <= int_meta;
            case (state)
                IDLE: begin
                    if (read) begin
                        tcnt <= '0;
                        idx  <= '0;
                    end
                end
                WAIT_INT: begin
                    if (int_sync) tcnt <= tcnt + TCNT_W'(1);
                end
                SETUP: scnt <= '0;
                STROBE: begin
                    scnt <= scnt + SCNT_W'(1);
                    if (strobe_last) begin
                        out_data <= tdc_data;
                        out_idx  <= idx;
                    end
                end
                PUSH: begin
                    if (out_ready && (idx < IDX_LAST)) idx <= idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the state. The strobe is driven low only in
    // STROBE and tdc_init is driven only in INIT, so the two can never overlap.
    always_comb begin
        busy        = (state != IDLE);
        tdc_rd_n    = (state != STROBE);
        tdc_init    = (state == INIT);
        out_valid   = (state == PUSH);
        tdc_addr    = '0;
        if ((state == SETUP) || (state == STROBE) || (state == PUSH)) begin
            tdc_addr = cur_addr;
        end
        timeout_err = (state == WAIT_INT) && int_sync && wait_expired;
        overrun     = read && (state != IDLE);
    end

endmodule
